// File: rtl/pe_pkg.sv
// Shared widths, tree-depth helpers and the pipeline sideband type for the dot-product PE.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pe_pkg;

    localparam int PE_NUM_LANES_DEF = 5;
    localparam int PE_DATA_W_DEF    = 8;
    localparam int PE_ACC_W_DEF     = 32;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } pe_sb_t;

    function automatic int pe_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Number of live elements at tree level k (level 0 = the products).
    function automatic int pe_lvl_cnt(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Registered binary reduction of NUM_LANES signed IN_W values, odd element forwarded.
// Latency: clog2(NUM_LANES) cycles, one register level per tree stage.
// Backpressure: en_i low freezes every level.
module pe_adder_tree
    import pe_pkg::*;
#(
    parameter int NUM_LANES = PE_NUM_LANES_DEF,
    parameter int IN_W      = 2 * PE_DATA_W_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         en_i,
    input  logic [NUM_LANES*IN_W-1:0]                    in_dat_i,
    output logic [IN_W+pe_clog2(NUM_LANES)-1:0]          sum_o
);

    localparam int TD    = pe_clog2(NUM_LANES);
    localparam int OUT_W = IN_W + TD;

    // Levels are stored at the final width; level k only ever carries IN_W+k
    // significant bits, the rest are sign copies.
    logic signed [OUT_W-1:0] stg   [TD][NUM_LANES];
    logic signed [OUT_W-1:0] lvl_d [TD][NUM_LANES];
    logic signed [OUT_W-1:0] lvl_q [TD][NUM_LANES];

    function automatic int clampi(input int x);
        return (x < NUM_LANES) ? x : NUM_LANES - 1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            stg[0][i] = OUT_W'($signed(in_dat_i[i*IN_W +: IN_W]));
        end
        for (int k = 1; k < TD; k++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                stg[k][i] = lvl_q[k-1][i];
            end
        end
        for (int k = 0; k < TD; k++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lvl_d[k][i] = '0;
                if (2 * i + 1 < pe_lvl_cnt(NUM_LANES, k)) begin
                    lvl_d[k][i] = stg[k][clampi(2 * i)] + stg[k][clampi(2 * i + 1)];
                end else if (2 * i < pe_lvl_cnt(NUM_LANES, k)) begin
                    lvl_d[k][i] = stg[k][clampi(2 * i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TD; k++) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    lvl_q[k][i] <= '0;
                end
            end
        end else if (en_i) begin
            for (int k = 0; k < TD; k++) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    lvl_q[k][i] <= lvl_d[k][i];
                end
            end
        end
    end

    assign sum_o = lvl_q[TD-1][0];

endmodule

// File: rtl/pe_dot_acc.sv
// Pipelined signed dot product of NUM_LANES lanes accumulated over first..last beats.
// Latency: clog2(NUM_LANES)+2 cycles from accepted last beat to out_valid.
// Backpressure: in_ready drops while a result waits on out_ready; PE_ACC_SAT_EN adds clamping and sat_flag.
module pe_dot_acc
    import pe_pkg::*;
#(
    parameter int NUM_LANES = PE_NUM_LANES_DEF,
    parameter int DATA_W    = PE_DATA_W_DEF,
    parameter int ACC_W     = PE_ACC_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [NUM_LANES*DATA_W-1:0]   ifm_vec,
    input  logic [NUM_LANES*DATA_W-1:0]   wgt_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_W-1:0]              out_data
`ifdef PE_ACC_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    localparam int TD     = pe_clog2(NUM_LANES);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + TD;

    logic                          en;
    logic [NUM_LANES*PROD_W-1:0]   prod_d, prod_q;
    pe_sb_t                        sb_in;
    pe_sb_t                        sb_q [TD+1];
    logic signed [SUM_W-1:0]       tree_sum;
    logic signed [ACC_W-1:0]       sum_ext, base, upd;
    logic signed [ACC_W-1:0]       acc_d, acc_q, out_data_d, out_data_q;
    logic                          out_valid_d, out_valid_q;
    logic                          beat, fin;

    // A held result freezes the whole pipe so nothing behind it can be lost.
    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        prod_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            prod_d[i*PROD_W +: PROD_W] = PROD_W'($signed(ifm_vec[i*DATA_W +: DATA_W]))
                                       * PROD_W'($signed(wgt_vec[i*DATA_W +: DATA_W]));
        end
        sb_in       = '0;
        sb_in.vld   = in_valid && en;
        sb_in.first = in_first;
        sb_in.last  = in_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            for (int k = 0; k <= TD; k++) begin
                sb_q[k] <= '0;
            end
        end else if (en) begin
            prod_q  <= prod_d;
            sb_q[0] <= sb_in;
            for (int k = 1; k <= TD; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    pe_adder_tree #(
        .NUM_LANES (NUM_LANES),
        .IN_W      (PROD_W)
    ) u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .in_dat_i (prod_q),
        .sum_o    (tree_sum)
    );

`ifdef PE_ACC_SAT_EN
    logic signed [ACC_W:0] wide;
    logic                  ovf;
    logic                  sat_d, sat_q;
`endif

    always_comb begin
        sum_ext = ACC_W'(tree_sum);
        base    = sb_q[TD].first ? '0 : acc_q;
        beat    = en && sb_q[TD].vld;
        fin     = beat && sb_q[TD].last;
`ifdef PE_ACC_SAT_EN
        wide = {base[ACC_W-1], base} + {sum_ext[ACC_W-1], sum_ext};
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        upd  = wide[ACC_W-1:0];
        if (ovf) begin
            upd = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        sat_d = sat_q;
        if (beat) begin
            sat_d = sb_q[TD].first ? ovf : (sat_q | ovf);
        end
`else
        upd = base + sum_ext;
`endif
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (beat) begin
            acc_d = sb_q[TD].last ? '0 : upd;
        end
        if (fin) begin
            out_data_d = upd;
        end
        if (en) begin
            out_valid_d = fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef PE_ACC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_pe_dot_acc.sv
// Bench for pe_dot_acc: directed literal cases plus randomized beats against a dot-product model.
module tb_pe_dot_acc;

    localparam int N   = 5;
    localparam int DW  = 8;
    localparam int AW  = 24;
    localparam int LAT = 5;
    localparam longint MOD  = longint'(1) << AW;
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_first, in_last;
    logic [N*DW-1:0]   ifm_vec, wgt_vec;
    logic              out_valid, out_ready;
    logic [AW-1:0]     out_data;
`ifdef PE_ACC_SAT_EN
    logic              sat_flag;
`endif

    pe_dot_acc #(.NUM_LANES(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .ifm_vec   (ifm_vec),
        .wgt_vec   (wgt_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PE_ACC_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;
    longint stalls = 0;
    bit     fresh  = 1;
    bit     rnd_done;

    typedef struct {
        longint data;
        longint acc_cyc;
        longint stalls;
        bit     sat;
    } exp_t;
    exp_t   exp_q[$];
    longint m_acc = 0;
    bit     m_sat = 0;

    task automatic check(input string name, input longint act, input longint expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint beat_sum(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        end
        return s;
    endfunction

    function automatic logic [N*DW-1:0] fill(input int v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v[DW-1:0];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] lane0(input int v);
        logic [N*DW-1:0] r;
        r = '0;
        r[DW-1:0] = v[DW-1:0];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rnd_vec();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Reference: accumulate plain integer dot products, then wrap or clamp to ACC_W.
    task automatic model_beat();
        longint t;
        bit     o;
        t = (in_first ? 0 : m_acc) + beat_sum(ifm_vec, wgt_vec);
        o = (t > MAXV) || (t < MINV);
`ifdef PE_ACC_SAT_EN
        if (t > MAXV) t = MAXV;
        if (t < MINV) t = MINV;
        m_sat = in_first ? o : (m_sat | o);
`else
        t = ((t % MOD) + MOD) % MOD;
        if (t > MAXV) t -= MOD;
        m_sat = o;
`endif
        if (in_last) begin
            exp_q.push_back('{data: t, acc_cyc: cyc, stalls: stalls, sat: m_sat});
            m_acc = 0;
        end else begin
            m_acc = t;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_acc = 0;
            m_sat = 0;
            fresh = 1;
        end else begin
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_result: out_data=%0d while no result outstanding", $signed(out_data));
                end else begin
                    check("out_data", longint'($signed(out_data)), exp_q[0].data);
                    if (fresh) begin
                        fresh = 0;
                        if (stalls == exp_q[0].stalls) check("latency", cyc - exp_q[0].acc_cyc, LAT);
`ifdef PE_ACC_SAT_EN
                        check("sat_flag", sat_flag, exp_q[0].sat);
`endif
                    end
                end
            end
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (!in_ready) stalls++;
            if (in_valid && in_ready) model_beat();
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                fresh = 1;
            end
        end
    end

    task automatic send(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input bit f, input bit l);
        bit took = 0;
        in_valid = 1'b1;
        ifm_vec  = a;
        wgt_vec  = b;
        in_first = f;
        in_last  = l;
        for (int k = 0; k < 500 && !took; k++) begin
            @(negedge clk);
            if (in_ready) took = 1;
        end
        if (!took) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input longint expv);
        bit got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                check(name, longint'($signed(out_data)), expv);
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: out_valid=0 after 200 cycles, expected result %0d", name, expv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        ifm_vec = '0; wgt_vec = '0; out_ready = 1'b1; rnd_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // single beat, 5 * (3 * -2)
        send(fill(3), fill(-2), 1, 1);
        wait_out("single_beat", -30);
        idle(3);

        // three-beat accumulation 10 + 20 - 5, then a first-less beat starts from 0
        send(lane0(10), lane0(1), 1, 0);
        send(lane0(4), lane0(5), 0, 0);
        send(lane0(-5), lane0(1), 0, 1);
        wait_out("three_beat", 25);
        send(fill(1), fill(1), 0, 1);
        wait_out("after_last_acc0", 5);
        idle(3);

        // output stall: three results queued behind out_ready low
        out_ready = 1'b0;
        fork
            begin
                send(fill(1), fill(2), 1, 1);
                send(fill(2), fill(2), 1, 1);
                send(fill(-1), fill(3), 1, 1);
            end
            begin
                bit seen = 0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                end
                if (!seen) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stall_first: out_valid=0, expected 1 within 50 cycles");
                end
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_hold", longint'($signed(out_data)), 10);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(20);
        check("stall_drain", exp_q.size(), 0);

        // reset two beats into an accumulation
        send(fill(5), fill(7), 1, 0);
        send(fill(6), fill(-3), 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send(fill(2), fill(3), 1, 1);
        wait_out("after_reset", 30);
        idle(3);

        // extremes: 200 beats of 5 * 16384 overflow a 24-bit accumulator
        for (int i = 0; i < 200; i++) begin
            send(fill(-128), fill(-128), i == 0, i == 199);
        end
`ifdef PE_ACC_SAT_EN
        wait_out("extreme_clamp", 8388607);
        check("extreme_sat_flag", sat_flag, 1);
`else
        wait_out("extreme_wrap", -393216);
`endif
        idle(3);

        // random beats, bubbles and output backpressure
        fork
            begin
                for (int t = 0; t < 80; t++) begin
                    int nb;
                    bit nf;
                    nb = $urandom_range(1, 4);
                    nf = ($urandom_range(0, 9) == 0);
                    for (int b = 0; b < nb; b++) begin
                        idle($urandom_range(0, 2));
                        if ($urandom_range(0, 7) == 0)
                            send(fill(-128), fill(-128), (b == 0) && !nf, b == nb - 1);
                        else
                            send(rnd_vec(), rnd_vec(), (b == 0) && !nf, b == nb - 1);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(30);
        check("final_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
